// File: rtl/rvv_vd_writeback_if.sv
// rvv_vd_writeback_if: lane result bus from the ALU lanes plus the register file write port
interface rvv_vd_writeback_if #(
  parameter int VLEN = 128,
  parameter int NB_LANES = 1
);
  logic [(64<<NB_LANES)-1:0] lane_vd;
  logic [(17<<NB_LANES)-1:0] lane_idx;
  logic [(1<<NB_LANES)-1:0] lane_valid;
  logic alu_done;
  logic wb_valid;
  logic [VLEN-1:0] wb_data;
  logic wb_ready;
  modport master (output lane_vd, lane_idx, lane_valid, alu_done, wb_ready, input wb_valid, wb_data);
  modport slave (input lane_vd, lane_idx, lane_valid, alu_done, wb_ready, output wb_valid, wb_data);
endinterface

// File: rtl/rvv_vd_writeback.sv
// rvv_vd_writeback: gathers lane element results into a vd buffer with mask/tail-undisturbed policy and writes it back
module rvv_vd_writeback #(
  parameter int VLEN = 128,
  parameter int NB_LANES = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic [VLEN-1:0] vd_old,
  input  logic [VLEN-1:0] v0_mask,
  input  logic vm,
  input  logic [2:0] vsew,
  input  logic [16:0] vl,
  input  logic mask_dest,
  output logic busy,
  rvv_vd_writeback_if.slave bus
);
  localparam int LANES = 1 << NB_LANES;
  localparam int AW = $clog2(VLEN);
  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_t;
  state_t state;
  logic [VLEN-1:0] vd_buf, v0_q, nb, wmask, wdata;
  logic vm_q, mask_dest_q, en;
  logic [2:0] vsew_q;
  logic [16:0] vl_q, idx;
  logic [63:0] d, sew_mask;
  logic [31:0] sh, limit;
  assign busy = state != IDLE;
  assign sh = 32'(vsew_q) + 32'd3;
  assign limit = mask_dest_q ? 32'(VLEN) : 32'(VLEN) >> sh;
  assign sew_mask = vsew_q >= 3'd3 ? '1 : (64'd1 << (8 << vsew_q)) - 64'd1;
  // Lanes are merged in ascending order so a duplicate index resolves to the highest lane.
  always_comb begin
    nb = vd_buf;
    idx = '0;
    d = '0;
    en = 1'b0;
    wmask = '0;
    wdata = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = bus.lane_idx[17*k +: 17];
      d = bus.lane_vd[64*k +: 64];
      en = bus.lane_valid[k] && idx < vl_q && 32'(idx) < limit
           && (vm_q || (32'(idx) < VLEN && v0_q[idx[AW-1:0]]));
      wmask = mask_dest_q ? VLEN'(1) << idx : VLEN'(sew_mask) << (32'(idx) << sh);
      wdata = mask_dest_q ? VLEN'(d[0]) << idx : VLEN'(d & sew_mask) << (32'(idx) << sh);
      nb = en ? (nb & ~wmask) | wdata : nb;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      vd_buf <= '0;
      v0_q <= '0;
      vm_q <= 1'b0;
      vsew_q <= '0;
      vl_q <= '0;
      mask_dest_q <= 1'b0;
      bus.wb_valid <= 1'b0;
      bus.wb_data <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= ACCUM;
          vd_buf <= vd_old;
          v0_q <= v0_mask;
          vm_q <= vm;
          vsew_q <= vsew;
          vl_q <= vl;
          mask_dest_q <= mask_dest;
        end
        ACCUM: begin
          vd_buf <= nb;
          if (bus.alu_done) begin
            state <= WRITE;
            bus.wb_valid <= 1'b1;
            bus.wb_data <= nb;
          end
        end
        default: if (bus.wb_ready) begin
          state <= IDLE;
          bus.wb_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
